// File: rtl/soc_pio_pkg.sv
// Shared register map and field widths for the event-capture PIO.
package soc_pio_pkg;

  localparam int BUS_W     = 32;
  localparam int EVT_CNT_W = 16;
  localparam int TS_W      = 32;

  localparam logic [3:0] ADDR_DATA_IN    = 4'd0;
  localparam logic [3:0] ADDR_DATA_OUT   = 4'd1;
  localparam logic [3:0] ADDR_IRQ_MASK   = 4'd2;
  localparam logic [3:0] ADDR_CAPTURE    = 4'd3;
  localparam logic [3:0] ADDR_OUTSET     = 4'd4;
  localparam logic [3:0] ADDR_OUTCLR     = 4'd5;
  localparam logic [3:0] ADDR_RISE_EN    = 4'd6;
  localparam logic [3:0] ADDR_FALL_EN    = 4'd7;
  localparam logic [3:0] ADDR_LEVEL_MODE = 4'd8;
  localparam logic [3:0] ADDR_EVT_CNT    = 4'd9;
  localparam logic [3:0] ADDR_TSTAMP     = 4'd10;
  localparam logic [3:0] ADDR_CYCLES     = 4'd11;

  localparam logic [EVT_CNT_W-1:0] EVT_CNT_MAX = '1;
  localparam logic [EVT_CNT_W-1:0] EVT_CNT_ONE = {{(EVT_CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [EVT_CNT_W-1:0] sat_inc(input logic [EVT_CNT_W-1:0] v);
    return (v == EVT_CNT_MAX) ? v : v + EVT_CNT_ONE;
  endfunction

endpackage

// File: rtl/soc_pio_sync_edge.sv
// Input synchroniser with registered rise/fall detection, held off until the
// chain has flushed its reset contents after reset release.
module soc_pio_sync_edge #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  localparam logic [2:0] ARM_DONE = 3'(STAGES + 1);

  logic [STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]             r_prev;
  logic [WIDTH-1:0]             r_rise;
  logic [WIDTH-1:0]             r_fall;
  logic [2:0]                   r_arm_cnt;
  logic [WIDTH-1:0]             w_sync;
  logic                         w_armed;

  assign w_sync  = r_sync[STAGES-1];
  assign w_armed = (r_arm_cnt == ARM_DONE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync    <= '0;
      r_prev    <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_arm_cnt <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_data};
      r_prev <= w_sync;
      if (!w_armed) r_arm_cnt <= r_arm_cnt + 3'd1;
      // Until armed, a line that was already high at reset must not look like an edge.
      r_rise <= w_armed ? (w_sync & ~r_prev) : '0;
      r_fall <= w_armed ? (~w_sync & r_prev) : '0;
    end
  end

  assign o_sync = w_sync;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/soc_system_pio_event_capture.sv
// Avalon-MM PIO with per-bit edge capture, level/edge interrupts, output
// set/clear, saturating event counter and first-event timestamp.
module soc_system_pio_event_capture
  import soc_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [BUS_W-1:0]      writedata,
  output logic [BUS_W-1:0]      readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] r_out;
  logic [DATA_WIDTH-1:0] r_irq_mask;
  logic [DATA_WIDTH-1:0] r_capture;
  logic [DATA_WIDTH-1:0] r_rise_en;
  logic [DATA_WIDTH-1:0] r_fall_en;
  logic [DATA_WIDTH-1:0] r_level_mode;
  logic [EVT_CNT_W-1:0]  r_evt_cnt;
  logic [TS_W-1:0]       r_tstamp;
  logic [TS_W-1:0]       r_cycles;
  logic [BUS_W-1:0]      r_readdata;
  logic                  r_irq;

  logic [DATA_WIDTH-1:0] w_sync;
  logic [DATA_WIDTH-1:0] w_rise;
  logic [DATA_WIDTH-1:0] w_fall;
  logic [DATA_WIDTH-1:0] w_new;
  logic [DATA_WIDTH-1:0] w_wd;
  logic [DATA_WIDTH-1:0] w_w1c_mask;
  logic [DATA_WIDTH-1:0] w_cap_kept;
  logic [DATA_WIDTH-1:0] w_cap_next;
  logic [BUS_W-1:0]      w_rd_mux;
  logic                  w_wr;
  logic                  w_any_new;
  logic                  w_evt_clr;
  logic                  w_ts_load;

  soc_pio_sync_edge #(
    .WIDTH  (DATA_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .i_clk  (clk),
    .i_rst  (reset),
    .i_data (in_port),
    .o_sync (w_sync),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  function automatic logic [BUS_W-1:0] zext(input logic [DATA_WIDTH-1:0] v);
    logic [BUS_W-1:0] r;
    r = '0;
    r[DATA_WIDTH-1:0] = v;
    return r;
  endfunction

  assign w_wr       = chipselect & ~write_n;
  assign w_wd       = writedata[DATA_WIDTH-1:0];
  assign w_new      = (w_rise & r_rise_en) | (w_fall & r_fall_en);
  assign w_any_new  = |w_new;
  assign w_w1c_mask = (w_wr && address == ADDR_CAPTURE) ? w_wd : '0;
  // A fresh edge always survives a same-cycle W1C on its bit.
  assign w_cap_kept = r_capture & ~w_w1c_mask;
  assign w_cap_next = w_cap_kept | w_new;
  assign w_evt_clr  = w_wr && (address == ADDR_EVT_CNT);
  assign w_ts_load  = (w_cap_kept == '0) && w_any_new;

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA_IN:    w_rd_mux = zext(w_sync);
      ADDR_DATA_OUT:   w_rd_mux = zext(r_out);
      ADDR_IRQ_MASK:   w_rd_mux = zext(r_irq_mask);
      ADDR_CAPTURE:    w_rd_mux = zext(r_capture);
      ADDR_RISE_EN:    w_rd_mux = zext(r_rise_en);
      ADDR_FALL_EN:    w_rd_mux = zext(r_fall_en);
      ADDR_LEVEL_MODE: w_rd_mux = zext(r_level_mode);
      ADDR_EVT_CNT:    w_rd_mux = {{(BUS_W-EVT_CNT_W){1'b0}}, r_evt_cnt};
      ADDR_TSTAMP:     w_rd_mux = r_tstamp;
      ADDR_CYCLES:     w_rd_mux = r_cycles;
      default:         w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out        <= OUT_RESET;
      r_irq_mask   <= '0;
      r_capture    <= '0;
      r_rise_en    <= '1;
      r_fall_en    <= '0;
      r_level_mode <= '0;
      r_evt_cnt    <= '0;
      r_tstamp     <= '0;
      r_cycles     <= '0;
      r_readdata   <= '0;
      r_irq        <= 1'b0;
    end else begin
      r_readdata <= w_rd_mux;
      r_irq      <= |(r_irq_mask & ((r_level_mode & w_sync) | (~r_level_mode & r_capture)));
      r_capture  <= w_cap_next;
      r_cycles   <= r_cycles + 32'd1;
      if (w_ts_load) r_tstamp <= r_cycles;
      // Clear beats increment, but an event in the clearing cycle still counts once.
      if (w_evt_clr)      r_evt_cnt <= w_any_new ? EVT_CNT_ONE : '0;
      else if (w_any_new) r_evt_cnt <= sat_inc(r_evt_cnt);
      if (w_wr) begin
        case (address)
          ADDR_DATA_OUT:   r_out        <= w_wd;
          ADDR_IRQ_MASK:   r_irq_mask   <= w_wd;
          ADDR_OUTSET:     r_out        <= r_out | w_wd;
          ADDR_OUTCLR:     r_out        <= r_out & ~w_wd;
          ADDR_RISE_EN:    r_rise_en    <= w_wd;
          ADDR_FALL_EN:    r_fall_en    <= w_wd;
          ADDR_LEVEL_MODE: r_level_mode <= w_wd;
          default:         ;
        endcase
      end
    end
  end

  assign readdata = r_readdata;
  assign out_port = r_out;
  assign irq      = r_irq;

endmodule
